// File: rtl/matrix_stream_serializer_if.sv
// matrix_stream_serializer_if: matrix-in / beat-out handshake bundle (out_row_last only with MATRIX_SERIALIZER_ROW_LAST_EN)
interface matrix_stream_serializer_if #(
  parameter int WIDTH = 8,
  parameter int HEIGHT = 4,
  parameter int P = 8,
  parameter int ELEMS_PER_BEAT = 4
);
  logic [WIDTH*HEIGHT*P-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [ELEMS_PER_BEAT*P-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic busy;
`ifdef MATRIX_SERIALIZER_ROW_LAST_EN
  logic out_row_last;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid, out_last, busy, out_row_last);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid, out_last, busy, out_row_last);
`else
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid, out_last, busy);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid, out_last, busy);
`endif
endinterface

// File: rtl/matrix_stream_serializer.sv
// matrix_stream_serializer: streams a flattened matrix out as ELEMS_PER_BEAT-element beats, row-major from the MSBs
// Optional MATRIX_SERIALIZER_ROW_LAST_EN adds out_row_last on the last beat of each matrix row.
module matrix_stream_serializer #(
  parameter int WIDTH = 8,
  parameter int HEIGHT = 4,
  parameter int P = 8,
  parameter int ELEMS_PER_BEAT = 4
) (
  input logic clk,
  input logic rst_n,
  matrix_stream_serializer_if.slave bus
);
  localparam int MW = WIDTH*HEIGHT*P;
  localparam int BEAT_W = ELEMS_PER_BEAT*P;
  localparam int NBEATS = WIDTH*HEIGHT/ELEMS_PER_BEAT;
  localparam int CW = NBEATS > 1 ? $clog2(NBEATS) : 1;
  localparam int BPR = WIDTH/ELEMS_PER_BEAT;
  if (WIDTH % ELEMS_PER_BEAT != 0) begin : g_bad
    $error("ELEMS_PER_BEAT must divide WIDTH");
  end
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_n;
  logic [MW-1:0] sr;
  logic [CW-1:0] cnt;
  logic last, load, adv;
  assign last = (state == STREAM) && (cnt == CW'(NBEATS-1));
  assign bus.in_ready = (state == IDLE) || (last && bus.out_ready);
  assign bus.out_valid = (state == STREAM);
  assign bus.out_last = last;
  assign bus.busy = (state == STREAM);
  assign bus.out_data = sr[MW-1 -: BEAT_W];
  assign load = bus.in_valid && bus.in_ready;
  assign adv = bus.out_valid && bus.out_ready && !last;
`ifdef MATRIX_SERIALIZER_ROW_LAST_EN
  assign bus.out_row_last = (state == STREAM) && ((32'(cnt) + 1) % BPR == 0);
`endif
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (bus.in_valid ? STREAM : IDLE)
                              : ((last && bus.out_ready && !bus.in_valid) ? IDLE : STREAM);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        sr <= bus.in_data;
        cnt <= '0;
      end else if (adv) begin
        sr <= sr << BEAT_W;
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_matrix_stream_serializer.sv
// tb_matrix_stream_serializer: directed checks of the default 4x8 matrix serializer
module tb_matrix_stream_serializer;
  localparam int MW = 256;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  matrix_stream_serializer_if #(.WIDTH(8), .HEIGHT(4), .P(8), .ELEMS_PER_BEAT(4)) bus ();
  matrix_stream_serializer #(.WIDTH(8), .HEIGHT(4), .P(8), .ELEMS_PER_BEAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [MW-1:0] mk(input logic [7:0] off);
    logic [MW-1:0] m = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++)
        m[MW-1-(i*8+j)*8 -: 8] = off + 8'(16*i + j);
    return m;
  endfunction
  function automatic logic [31:0] beat(input logic [7:0] off, input int b);
    logic [31:0] r;
    for (int e = 0; e < 4; e++)
      r[31-e*8 -: 8] = off + 8'(16*(b/2) + 4*(b%2) + e);
    return r;
  endfunction
  task automatic accept(input logic [7:0] off);
    @(negedge clk);
    bus.in_data = mk(off);
    bus.in_valid = 1;
    bus.out_ready = 1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: got %b want 1", bus.in_ready);
    end
  endtask
  task automatic test_reset();
    rst_n = 0;
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.in_data = mk(8'h00);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, bus.busy} !== 4'b1000 || bus.out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got rdy/vld/last/busy=%b data=%h want 1000 data=0",
               {bus.in_ready, bus.out_valid, bus.out_last, bus.busy}, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_basic(input logic [7:0] off);
    accept(off);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      bus.in_valid = 0;
      #1;
      checks++;
      if (bus.out_data !== beat(off, b)) begin
        errors++;
        $display("FAIL basic_data[%0d]: got %h want %h", b, bus.out_data, beat(off, b));
      end
      checks++;
      if ({bus.out_valid, bus.busy, bus.out_last, bus.in_ready} !== {2'b11, b == 7, b == 7}) begin
        errors++;
        $display("FAIL basic_ctl[%0d]: got %b want %b", b,
                 {bus.out_valid, bus.busy, bus.out_last, bus.in_ready}, {2'b11, b == 7, b == 7});
      end
`ifdef MATRIX_SERIALIZER_ROW_LAST_EN
      checks++;
      if (bus.out_row_last !== (b % 2 == 1)) begin
        errors++;
        $display("FAIL row_last[%0d]: got %b want %b", b, bus.out_row_last, b % 2 == 1);
      end
`endif
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL basic_idle: got vld/busy/rdy=%b want 001", {bus.out_valid, bus.busy, bus.in_ready});
    end
  endtask
  task automatic test_stall();
    int b = 0;
    int cyc = 0;
    accept(8'h00);
    while (b < 8 && cyc < 40) begin
      @(negedge clk);
      bus.in_valid = 0;
      bus.out_ready = (cyc % 2 == 0);
      #1;
      checks++;
      if (bus.out_data !== beat(8'h00, b) || bus.out_last !== (b == 7) || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_beat[%0d] cyc %0d: got %h last %b vld %b want %h last %b vld 1",
                 b, cyc, bus.out_data, bus.out_last, bus.out_valid, beat(8'h00, b), b == 7);
      end
      if (bus.out_ready) b++;
      cyc++;
    end
    checks++;
    if (cyc !== 15) begin
      errors++;
      $display("FAIL stall_cycles: got %0d want 15", cyc);
    end
    @(negedge clk);
    bus.out_ready = 1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle: got vld %b want 0", bus.out_valid);
    end
  endtask
  task automatic test_back_to_back();
    accept(8'h00);
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      bus.in_data = mk(8'h80);
      bus.in_valid = (b < 8);
      #1;
      checks++;
      if (bus.out_data !== beat(b < 8 ? 8'h00 : 8'h80, b % 8) || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %h vld %b want %h vld 1", b, bus.out_data, bus.out_valid,
                 beat(b < 8 ? 8'h00 : 8'h80, b % 8));
      end
      checks++;
      if ({bus.out_last, bus.in_ready} !== {b % 8 == 7, b % 8 == 7}) begin
        errors++;
        $display("FAIL b2b_ctl[%0d]: got last/rdy %b want %b", b, {bus.out_last, bus.in_ready},
                 {b % 8 == 7, b % 8 == 7});
      end
    end
    @(negedge clk);
    bus.in_valid = 0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got busy %b want 0", bus.busy);
    end
  endtask
  task automatic test_reset_mid();
    accept(8'h00);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      bus.in_valid = 0;
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_data !== beat(8'h00, 3)) begin
      errors++;
      $display("FAIL mid_beat3: got %h want %h", bus.out_data, beat(8'h00, 3));
    end
    rst_n = 0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.busy, bus.out_last} !== 4'b0100 || bus.out_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got vld/rdy/busy/last=%b data=%h want 0100 data=0",
               {bus.out_valid, bus.in_ready, bus.busy, bus.out_last}, bus.out_data);
    end
    @(negedge clk);
    rst_n = 1;
    test_basic(8'h40);
  endtask
  task automatic test_data_change();
    accept(8'h00);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      bus.in_valid = 0;
      bus.in_data = {8{$urandom}};
      #1;
      checks++;
      if (bus.out_data !== beat(8'h00, b)) begin
        errors++;
        $display("FAIL hold_data[%0d]: got %h want %h", b, bus.out_data, beat(8'h00, b));
      end
    end
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_basic(8'h00);
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_data_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_stream_serializer.md
Name: matrix_stream_serializer

Overview:
- Sequences a flattened HEIGHT x WIDTH matrix of P-bit elements onto a narrow streaming bus, one beat of ELEMS_PER_BEAT elements per handshake.
- Sits downstream of the matrix flattening stage. Input word layout: element [0][0] in the MSBs, row-major toward the LSBs.
- Emits beats in the same order: row 0 first, lowest column first within each beat group.
- Ready/valid handshake on both sides. Supports back-to-back matrices with no bubble.

Parameters:
- WIDTH, 8, columns per matrix row.
- HEIGHT, 4, rows per matrix.
- P, 8, bits per element.
- ELEMS_PER_BEAT, 4, elements per output beat. Must divide WIDTH; otherwise $error at elaboration.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH*HEIGHT*P  flattened matrix, [0][0] at the MSBs.
- in_valid  input  1  in_data valid.
- in_ready  output  1  serializer can accept a matrix this cycle.
- out_data  output  ELEMS_PER_BEAT*P  current beat; lowest column index in the MSBs.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts beat.
- out_last  output  1  current beat is the last beat of the matrix.
- busy  output  1  a matrix is held (state STREAM).

Behaviour:
- Derived constants:
  - BEAT_W = ELEMS_PER_BEAT*P.
  - NBEATS = WIDTH*HEIGHT/ELEMS_PER_BEAT (default 8).
  - Beat counter width = $clog2(NBEATS), minimum 1.
- State machine:
  - IDLE: in_ready=1, out_valid=0. Accept (in_valid&in_ready) -> load shift register with in_data, beat_cnt=0, go to STREAM.
  - STREAM: out_valid=1, out_data = top BEAT_W bits of the shift register, out_last = (beat_cnt==NBEATS-1).
    - On out_valid&out_ready with !out_last: shift register left by BEAT_W (zero fill), beat_cnt+1, stay in STREAM.
    - On the last-beat handshake: if in_valid, load the new matrix, beat_cnt=0, stay in STREAM; else go to IDLE.
- in_ready = (state==IDLE) | (state==STREAM & out_last & out_ready). This is a combinational path out_ready -> in_ready, by design.
- Latency: the first beat appears on out_data the cycle after input acceptance.
- Throughput: one matrix per NBEATS cycles with out_ready held high and a new matrix offered on each last-beat cycle.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_last and beat_cnt hold; no advance.
- in_data is sampled only on acceptance. Later changes to in_data do not affect the beats in flight.
- in_valid in STREAM, other than on the last-beat handshake, is ignored; in_ready=0.
- Degenerate case NBEATS==1: every beat is last. in_ready follows out_ready in STREAM.
- Reset, asynchronous, any state: state=IDLE, shift register=0, beat_cnt=0. Immediately in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0. A matrix mid-stream is discarded.
- busy = (state==STREAM).

Optional Feature:
- Macro MATRIX_SERIALIZER_ROW_LAST_EN.
- Defined: adds output port out_row_last (1 bit). It is asserted with out_valid on the last beat of each matrix row, i.e. (beat_cnt+1) % (WIDTH/ELEMS_PER_BEAT) == 0. It is 0 at reset and in IDLE.
- Not defined: the port does not exist; all other behaviour is identical.

Test Plan:
- Defaults, A[i][j]=16*i+j, out_ready=1 -> 8 consecutive beats 0x00010203, 0x04050607, 0x10111213, 0x14151617, 0x20212223, 0x24252627, 0x30313233, 0x34353637. out_last only on beat 8; busy high for 8 cycles.
- Same matrix, out_ready toggling 1,0,1,0 -> each beat held stable while out_ready=0. 8 beats total, 15 cycles, no duplicates or drops.
- Two matrices, the second with in_valid held from cycle 0 -> second matrix accepted on the first matrix's last-beat cycle. 16 beats over 16 cycles with no gap; in_ready high only at the two acceptance points.
- rst_n pulsed low after beat 3 -> out_valid=0, in_ready=1 within the reset cycle. Next matrix streams from beat 0 with correct data.
- in_data changed every cycle after acceptance -> all 8 beats reflect the captured matrix only.
- MATRIX_SERIALIZER_ROW_LAST_EN defined, defaults -> out_row_last high on beats 2, 4, 6 and 8 only.
